// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: EX branch opcodes and
// direction-counter encodings.
package branch_predictor_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLEZ = 3'd2,
        BR_BGTZ = 3'd3,
        BR_BLTZ = 3'd4,
        BR_NONE = 3'd5
    } br_op_e;

    // Weakly-not-taken and weakly-taken encodings for a w-bit counter.
    function automatic int unsigned ctr_wnt(input int unsigned w);
        return (32'd1 << (w - 32'd1)) - 32'd1;
    endfunction

    function automatic int unsigned ctr_wt(input int unsigned w);
        return 32'd1 << (w - 32'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// IF lookup and EX resolution signals between the pipeline and the predictor.
interface branch_predictor_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] if_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;

    logic              ex_valid;
    logic [2:0]        ex_branch_op;
    logic [31:0]       ex_alu_out;
    logic [ADDR_W-1:0] ex_pc;
    logic [ADDR_W-1:0] ex_pc_plus4;
    logic [ADDR_W-1:0] ex_branch_addr;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_target;

    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;
    logic [31:0]       branch_cnt;
    logic [31:0]       miss_cnt;

    modport master (
        output if_pc, ex_valid, ex_branch_op, ex_alu_out, ex_pc, ex_pc_plus4,
               ex_branch_addr, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, miss_cnt
    );

    modport slave (
        input  if_pc, ex_valid, ex_branch_op, ex_alu_out, ex_pc, ex_pc_plus4,
               ex_branch_addr, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_predictor_table.sv
// Direct-mapped BTB with saturating direction counters: asynchronous IF read
// port, synchronous EX update port that owns the hit/allocate decision.
module bp_table
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned TAG_W  = 8,
    parameter int unsigned CTR_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic              rd_hit,
    output logic              rd_taken,
    output logic [ADDR_W-1:0] rd_tgt,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              wr_taken,
    input  logic [ADDR_W-1:0] wr_tgt
);
    localparam int unsigned      ENTRIES = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_wnt(CTR_W));
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_wt(CTR_W));
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q [ENTRIES];

    logic               wr_hit;
    logic [CTR_W-1:0]   wr_ctr;

    assign rd_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_taken = ctr_q[rd_idx][CTR_W-1];
    assign rd_tgt   = tgt_q[rd_idx];

    assign wr_hit   = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign wr_ctr   = ctr_q[wr_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else if (wr_en) begin
            if (wr_hit) begin
                if (wr_taken && (wr_ctr != CTR_MAX)) begin
                    ctr_q[wr_idx] <= wr_ctr + 1'b1;
                end else if (!wr_taken && (wr_ctr != '0)) begin
                    ctr_q[wr_idx] <= wr_ctr - 1'b1;
                end
            end else if (wr_taken) begin
                valid_q[wr_idx] <= 1'b1;
                ctr_q[wr_idx]   <= CTR_WT;
            end
        end
    end

    // NOTE: tag and target storage is deliberately left without reset; the
    // valid bits already mask stale contents and unreset arrays map to RAM.
    always_ff @(posedge clk) begin
        if (wr_en && wr_taken) begin
            tag_q[wr_idx] <= wr_tag;
            tgt_q[wr_idx] <= wr_tgt;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// EX-stage branch resolver with BTB-based IF prediction, mispredict/redirect
// generation and saturating resolved-branch / mispredict statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned TAG_W  = 8,
    parameter int unsigned CTR_W  = 2
) (
    input logic               clk,
    input logic               reset,
    branch_predictor_if.slave bp
);
    logic [IDX_W-1:0]  if_idx;
    logic [TAG_W-1:0]  if_tag;
    logic [IDX_W-1:0]  ex_idx;
    logic [TAG_W-1:0]  ex_tag;
    logic              rd_hit;
    logic              rd_taken;
    logic [ADDR_W-1:0] rd_tgt;
    logic [ADDR_W-1:0] if_pc_plus4;
    logic              is_br;
    logic              taken;
    logic              mispredict;
    logic [31:0]       branch_cnt_q;
    logic [31:0]       miss_cnt_q;
    logic              unused_ex_pc;

    assign if_idx       = bp.if_pc[IDX_W+1:2];
    assign if_tag       = bp.if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign ex_idx       = bp.ex_pc[IDX_W+1:2];
    assign ex_tag       = bp.ex_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign if_pc_plus4  = bp.if_pc + ADDR_W'(4);
    assign unused_ex_pc = ^{bp.ex_pc[ADDR_W-1:IDX_W+TAG_W+2], bp.ex_pc[1:0]};

    bp_table #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .CTR_W  (CTR_W)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (if_idx),
        .rd_tag   (if_tag),
        .rd_hit   (rd_hit),
        .rd_taken (rd_taken),
        .rd_tgt   (rd_tgt),
        .wr_en    (is_br && !reset),
        .wr_idx   (ex_idx),
        .wr_tag   (ex_tag),
        .wr_taken (taken),
        .wr_tgt   (bp.ex_branch_addr)
    );

    // Outputs are forced to their idle values while reset is held, including
    // mid-operation, so a stale EX branch cannot redirect fetch.
    always_comb begin
        is_br      = bp.ex_valid && (bp.ex_branch_op <= BR_BLTZ);
        taken      = (bp.ex_branch_op == BR_BEQ) ? (bp.ex_alu_out == '0)
                                                 : (bp.ex_alu_out != '0);
        mispredict = !reset && is_br &&
                     ((taken != bp.ex_pred_taken) ||
                      (taken && (bp.ex_pred_target != bp.ex_branch_addr)));
    end

    assign bp.pred_taken  = !reset && rd_hit && rd_taken;
    assign bp.pred_target = bp.pred_taken ? rd_tgt : if_pc_plus4;
    assign bp.mispredict  = mispredict;
    assign bp.redirect_pc = reset           ? '0                 :
                            (is_br && taken) ? bp.ex_branch_addr : bp.ex_pc_plus4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else if (is_br) begin
            if (branch_cnt_q != '1) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mispredict && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign bp.branch_cnt = branch_cnt_q;
    assign bp.miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: resolution vectors from a table plus
// hand-written multi-cycle sequences for training, reset and aliasing.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned CTR_W  = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    branch_predictor_if #(.ADDR_W(ADDR_W)) bp ();

    branch_predictor #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .CTR_W  (CTR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] alu;
        logic        valid;
        logic        pt;
        logic [1:0]  ptgt_sel;     // 0: pc+4, 1: branch addr, 2: branch addr+4
        logic        exp_br;
        logic        exp_misp;
        logic        exp_red_addr; // 1: redirect to branch addr, 0: pc+4
    } vec_t;

    vec_t vecs [11];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_idle();
        bp.ex_valid       = 1'b0;
        bp.ex_branch_op   = BR_NONE;
        bp.ex_alu_out     = '0;
        bp.ex_pc          = '0;
        bp.ex_pc_plus4    = 32'h4;
        bp.ex_branch_addr = '0;
        bp.ex_pred_taken  = 1'b0;
        bp.ex_pred_target = '0;
    endtask

    task automatic ex_drive(input logic [2:0] op, input logic [31:0] alu, input logic [31:0] pc,
                            input logic [31:0] addr, input logic pt, input logic [31:0] ptgt);
        bp.ex_valid       = 1'b1;
        bp.ex_branch_op   = op;
        bp.ex_alu_out     = alu;
        bp.ex_pc          = pc;
        bp.ex_pc_plus4    = pc + 32'd4;
        bp.ex_branch_addr = addr;
        bp.ex_pred_taken  = pt;
        bp.ex_pred_target = ptgt;
    endtask

    task automatic lookup(input string name, input logic [31:0] pc,
                          input logic exp_t, input logic [31:0] exp_tgt);
        bp.if_pc = pc;
        #1;
        check({name, " pred_taken"}, 32'(bp.pred_taken), 32'(exp_t));
        check({name, " pred_target"}, bp.pred_target, exp_tgt);
    endtask

    task automatic check_counts(input string name, input logic [31:0] eb, input logic [31:0] em);
        check({name, " branch_cnt"}, bp.branch_cnt, eb);
        check({name, " miss_cnt"}, bp.miss_cnt, em);
    endtask

    initial begin
        logic [31:0] pc, addr, ptgt, exp_red;
        logic [31:0] exp_branch, exp_miss;

        //         op        alu            v     pt    sel   br    misp  red_addr
        vecs[0]  = '{3'd0, 32'h0000_0000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{3'd0, 32'h0000_0000, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{3'd0, 32'h0000_0005, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'd0, 32'h0000_0005, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{3'd2, 32'h0000_0001, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{3'd3, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{3'd4, 32'hFFFF_FFFF, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{3'd5, 32'h0000_0001, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'd7, 32'h0000_0001, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'd1, 32'h0000_0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'd1, 32'h0000_0000, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};

        // Reset held: outputs idle even with a mispredicting branch in EX.
        reset    = 1'b1;
        bp.if_pc = 32'h0000_1234;
        ex_drive(BR_BNE, 32'd1, 32'h40, 32'h80, 1'b0, 32'h44);
        tick();
        tick();
        check("in reset pred_taken", 32'(bp.pred_taken), 32'd0);
        check("in reset pred_target", bp.pred_target, 32'h0000_1238);
        check("in reset mispredict", 32'(bp.mispredict), 32'd0);
        check("in reset redirect_pc", bp.redirect_pc, 32'd0);
        reset = 1'b0;
        ex_idle();

        // 1. Cold lookup and zero statistics.
        lookup("cold", 32'h0000_1234, 1'b0, 32'h0000_1238);
        check_counts("after reset", 32'd0, 32'd0);

        // 2. First taken bne allocates; same-cycle lookup sees the old state.
        bp.if_pc = 32'h40;
        ex_drive(BR_BNE, 32'd1, 32'h40, 32'h80, 1'b0, 32'h44);
        #1;
        check("bne first mispredict", 32'(bp.mispredict), 32'd1);
        check("bne first redirect", bp.redirect_pc, 32'h80);
        check("same-cycle lookup no bypass", 32'(bp.pred_taken), 32'd0);
        tick();
        ex_idle();
        lookup("after alloc", 32'h40, 1'b1, 32'h80);
        check_counts("after alloc", 32'd1, 32'd1);

        // 3. Saturate high, then two not-taken resolutions walk it back.
        for (int k = 0; k < 3; k++) begin
            ex_drive(BR_BNE, 32'd1, 32'h40, 32'h80, 1'b1, 32'h80);
            #1;
            check($sformatf("bne taken %0d mispredict", k), 32'(bp.mispredict), 32'd0);
            tick();
        end
        ex_idle();
        lookup("saturated", 32'h40, 1'b1, 32'h80);
        ex_drive(BR_BNE, 32'd0, 32'h40, 32'h80, 1'b1, 32'h80);
        #1;
        check("bne nt1 mispredict", 32'(bp.mispredict), 32'd1);
        check("bne nt1 redirect", bp.redirect_pc, 32'h44);
        tick();
        ex_idle();
        lookup("after nt1", 32'h40, 1'b1, 32'h80);
        ex_drive(BR_BNE, 32'd0, 32'h40, 32'h80, 1'b1, 32'h80);
        #1;
        check("bne nt2 mispredict", 32'(bp.mispredict), 32'd1);
        tick();
        ex_idle();
        lookup("after nt2", 32'h40, 1'b0, 32'h44);
        check_counts("after training", 32'd6, 32'd3);

        // Table-driven resolution vectors, each at its own BTB index.
        exp_branch = 32'd6;
        exp_miss   = 32'd3;
        bp.if_pc   = 32'h0;
        for (int i = 0; i < 11; i++) begin
            pc   = 32'h1000 + 32'(4 * i);
            addr = 32'h2000 + 32'(16 * i);
            case (vecs[i].ptgt_sel)
                2'd0:    ptgt = pc + 32'd4;
                2'd1:    ptgt = addr;
                default: ptgt = addr + 32'd4;
            endcase
            exp_red = vecs[i].exp_red_addr ? addr : pc + 32'd4;
            ex_drive(vecs[i].op, vecs[i].alu, pc, addr, vecs[i].pt, ptgt);
            bp.ex_valid = vecs[i].valid;
            #1;
            check($sformatf("vec%0d mispredict", i), 32'(bp.mispredict), 32'(vecs[i].exp_misp));
            check($sformatf("vec%0d redirect", i), bp.redirect_pc, exp_red);
            tick();
            exp_branch = exp_branch + 32'(vecs[i].exp_br);
            exp_miss   = exp_miss + 32'(vecs[i].exp_misp);
            check_counts($sformatf("vec%0d", i), exp_branch, exp_miss);
        end
        ex_idle();

        // 5. Non-branch op and invalid EX left the table untouched.
        lookup("op5 no alloc", 32'h101C, 1'b0, 32'h1020);
        lookup("invalid no alloc", 32'h1024, 1'b0, 32'h1028);
        lookup("beq alloc", 32'h1000, 1'b1, 32'h2000);

        // 6. Asynchronous reset mid-cycle, after 14 resolved branches.
        bp.if_pc = 32'h1000;
        ex_drive(BR_BNE, 32'd1, 32'h40, 32'h80, 1'b0, 32'h44);
        #1;
        check("pre-reset pred_taken", 32'(bp.pred_taken), 32'd1);
        reset = 1'b1;
        #1;
        check("async reset pred_taken", 32'(bp.pred_taken), 32'd0);
        check("async reset pred_target", bp.pred_target, 32'h1004);
        check("async reset mispredict", 32'(bp.mispredict), 32'd0);
        check("async reset redirect", bp.redirect_pc, 32'd0);
        check_counts("async reset", 32'd0, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        ex_idle();
        lookup("post-reset 0x1000", 32'h1000, 1'b0, 32'h1004);
        lookup("post-reset 0x40", 32'h40, 1'b0, 32'h44);

        // Aliasing: 0x140 shares 0x40's index with a different tag.
        ex_drive(BR_BNE, 32'd1, 32'h40, 32'h80, 1'b0, 32'h44);
        #1;
        check("realloc mispredict", 32'(bp.mispredict), 32'd1);
        tick();
        ex_idle();
        lookup("realloc 0x40", 32'h40, 1'b1, 32'h80);
        lookup("alias tag miss", 32'h140, 1'b0, 32'h144);
        ex_drive(BR_BNE, 32'd1, 32'h140, 32'h900, 1'b0, 32'h144);
        #1;
        check("alias mispredict", 32'(bp.mispredict), 32'd1);
        check("alias redirect", bp.redirect_pc, 32'h900);
        tick();
        ex_idle();
        lookup("alias new entry", 32'h140, 1'b1, 32'h900);
        lookup("alias evicted", 32'h40, 1'b0, 32'h44);
        check_counts("final", 32'd2, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
